// File: rtl/top_out_rx64.sv
// 8N1 UART receiver that packs eight consecutive bytes into one 64-bit word (first byte in [7:0]).
// Optional macro FRAME_ERR_EN: check stop bits, drop bad bytes and pulse frame_err.
`timescale 1ns/1ps
module top_out_rx64 #(
  parameter int CLK_F    = 50_000_000,
  parameter int UART_BPS = 115200,
  parameter int CLK_GOAL = CLK_F / UART_BPS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        uart_rxd,
  output logic [63:0] data_64,
  output logic        data_out_done
`ifdef FRAME_ERR_EN
  ,
  output logic        frame_err
`endif
);

  localparam int CW = $clog2(CLK_GOAL);
  localparam logic [CW-1:0] MID_CNT  = CW'(CLK_GOAL / 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLK_GOAL - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t         state_q;
  logic           rxMeta_q;
  logic           rxSync_q;
  logic           rxPrev_q;
  logic [CW-1:0]  baudCnt_q;
  logic [2:0]     bitIdx_q;
  logic [7:0]     shift_q;
  logic [2:0]     byteCnt_q;
  logic [63:0]    assembly_q;
  logic           wordReady_q;

  logic fallEdge;
  logic midBit;

  assign fallEdge = rxPrev_q & ~rxSync_q;
  assign midBit   = (baudCnt_q == MID_CNT);

  // wordReady_q delays publication by one clock so data_64 only ever shows complete words
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      rxMeta_q      <= 1'b1;
      rxSync_q      <= 1'b1;
      rxPrev_q      <= 1'b1;
      baudCnt_q     <= '0;
      bitIdx_q      <= '0;
      shift_q       <= '0;
      byteCnt_q     <= '0;
      assembly_q    <= '0;
      wordReady_q   <= 1'b0;
      data_64       <= '0;
      data_out_done <= 1'b0;
`ifdef FRAME_ERR_EN
      frame_err     <= 1'b0;
`endif
    end else begin
      rxMeta_q      <= uart_rxd;
      rxSync_q      <= rxMeta_q;
      rxPrev_q      <= rxSync_q;
      data_out_done <= 1'b0;
`ifdef FRAME_ERR_EN
      frame_err     <= 1'b0;
`endif

      if (wordReady_q) begin
        data_64       <= assembly_q;
        data_out_done <= 1'b1;
        assembly_q    <= '0;
        wordReady_q   <= 1'b0;
      end

      if (state_q != IDLE) begin
        baudCnt_q <= (baudCnt_q == LAST_CNT) ? '0 : baudCnt_q + 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (fallEdge) begin
            state_q   <= START;
            baudCnt_q <= '0;
          end
        end
        START: begin
          if (midBit) begin
            if (!rxSync_q) begin
              state_q  <= DATA;
              bitIdx_q <= '0;
            end else begin
              state_q <= IDLE;
            end
          end
        end
        DATA: begin
          if (midBit) begin
            shift_q  <= {rxSync_q, shift_q[7:1]};
            bitIdx_q <= bitIdx_q + 3'd1;
            if (bitIdx_q == 3'd7) begin
              state_q <= STOP;
            end
          end
        end
        STOP: begin
          if (midBit) begin
`ifdef FRAME_ERR_EN
            if (!rxSync_q) begin
              frame_err <= 1'b1;
              state_q   <= WAIT_HIGH;
            end else begin
              assembly_q[{byteCnt_q, 3'b000} +: 8] <= shift_q;
              byteCnt_q <= byteCnt_q + 3'd1;
              if (byteCnt_q == 3'd7) begin
                wordReady_q <= 1'b1;
              end
              state_q <= IDLE;
            end
`else
            assembly_q[{byteCnt_q, 3'b000} +: 8] <= shift_q;
            byteCnt_q <= byteCnt_q + 3'd1;
            if (byteCnt_q == 3'd7) begin
              wordReady_q <= 1'b1;
            end
            state_q <= IDLE;
`endif
          end
        end
`ifdef FRAME_ERR_EN
        WAIT_HIGH: begin
          if (rxSync_q) begin
            state_q <= IDLE;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_top_out_rx64.sv
// Scoreboard bench for top_out_rx64: expected words are queued as frames are driven and popped on each strobe.
// Also covers the FRAME_ERR_EN build when that macro is defined.
`timescale 1ns/1ps
module tb_top_out_rx64;

  localparam int CLK_NS   = 20;
  localparam int CLK_GOAL = 16;
  localparam int BIT_NS   = CLK_NS * CLK_GOAL;

  logic        clk;
  logic        rst;
  logic        uart_rxd;
  logic [63:0] data_64;
  logic        data_out_done;
`ifdef FRAME_ERR_EN
  logic        frame_err;
  int          frameErrPulses;
  logic        frameErrLast;
`endif

  logic [63:0] expQ[$];
  logic [63:0] heldWord;
  int          checkCount;
  int          errorCount;
  int          strobeCount;
  int          expectedStrobes;
  logic        doneLast;
  logic        rstLast;

  top_out_rx64 #(
    .CLK_F   (50_000_000),
    .UART_BPS(115200),
    .CLK_GOAL(CLK_GOAL)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .uart_rxd     (uart_rxd),
    .data_64      (data_64),
    .data_out_done(data_out_done)
`ifdef FRAME_ERR_EN
    ,
    .frame_err    (frame_err)
`endif
  );

  initial clk = 1'b0;
  always #(CLK_NS / 2) clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  task automatic sendFrame(input logic [7:0] b, input logic stopBit, input int gapNs);
    uart_rxd = 1'b0;
    #(BIT_NS);
    for (int i = 0; i < 8; i++) begin
      uart_rxd = b[i];
      #(BIT_NS);
    end
    uart_rxd = stopBit;
    #(BIT_NS);
    uart_rxd = 1'b1;
    #(gapNs);
  endtask

  task automatic applyStimulus(input logic [63:0] word);
    expQ.push_back(word);
    expectedStrobes++;
    for (int i = 0; i < 8; i++) begin
      sendFrame(word[8*i +: 8], 1'b1, 40);
    end
  endtask

  task automatic waitDrained(input string tag);
    #(3 * BIT_NS);
    checkOutput(tag, 64'(expQ.size()), 64'd0);
  endtask

  task automatic pulseReset(input int cycles);
    @(negedge clk);
    rst      = 1'b1;
    heldWord = '0;
    repeat (cycles) @(negedge clk);
    rst = 1'b0;
  endtask

  // Strobe handling and the "data_64 holds between completions" check run on every falling edge
  always @(negedge clk) begin
    if (!rst && !rstLast) begin
      if (data_out_done) begin
        strobeCount++;
        checkOutput("strobe width", {63'd0, doneLast}, 64'd0);
        if (expQ.size() == 0) begin
          checkOutput("unexpected strobe", 64'd1, 64'd0);
        end else begin
          heldWord = expQ.pop_front();
          checkOutput("word value", data_64, heldWord);
        end
      end else begin
        checkOutput("data hold", data_64, heldWord);
      end
    end
`ifdef FRAME_ERR_EN
    if (!rst && frame_err) begin
      frameErrPulses++;
      checkOutput("frame_err width", {63'd0, frameErrLast}, 64'd0);
    end
    frameErrLast = frame_err;
`endif
    doneLast = data_out_done;
    rstLast  = rst;
  end

  initial begin
    logic [7:0] fb[9];
    int         strobesBefore;
    checkCount      = 0;
    errorCount      = 0;
    strobeCount     = 0;
    expectedStrobes = 0;
    heldWord        = '0;
    doneLast        = 1'b0;
    rstLast         = 1'b1;
    uart_rxd        = 1'b1;
    rst             = 1'b1;
`ifdef FRAME_ERR_EN
    frameErrPulses  = 0;
    frameErrLast    = 1'b0;
`endif

    repeat (2) @(negedge clk);
    checkOutput("reset data_64", data_64, 64'd0);
    checkOutput("reset done", {63'd0, data_out_done}, 64'd0);
    rst = 1'b0;
    #100000;
    checkOutput("idle data_64", data_64, 64'd0);
    checkOutput("idle strobes", 64'(strobeCount), 64'd0);

    applyStimulus(64'h91EF9BE64104FB5D);
    waitDrained("nominal drained");
    checkOutput("nominal held", data_64, 64'h91EF9BE64104FB5D);

    uart_rxd = 1'b0;
    #100;
    uart_rxd = 1'b1;
    #(2 * BIT_NS);
    checkOutput("glitch no strobe", 64'(strobeCount), 64'd1);
    applyStimulus(64'hA5A55A5A3C3CC3C3);
    waitDrained("post-glitch drained");

    applyStimulus(64'h0123456789ABCDEF);
    applyStimulus(64'hFFFFFFFF00000000);
    waitDrained("two words drained");
    checkOutput("word B held", data_64, 64'hFFFFFFFF00000000);

    for (int i = 0; i < 3; i++) begin
      sendFrame(8'hC0 + 8'(i), 1'b1, 40);
    end
    #(BIT_NS);
    pulseReset(2);
    checkOutput("mid-word reset", data_64, 64'd0);
    applyStimulus(64'h8877665544332211);
    waitDrained("after reset drained");
    checkOutput("after reset held", data_64, 64'h8877665544332211);

`ifdef FRAME_ERR_EN
    fb = '{8'h10, 8'h21, 8'h32, 8'hEE, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};
    strobesBefore = strobeCount;
    for (int i = 0; i < 8; i++) begin
      sendFrame(fb[i], (i == 3) ? 1'b0 : 1'b1, (i == 3) ? BIT_NS : 40);
    end
    #(3 * BIT_NS);
    checkOutput("no strobe on bad word", 64'(strobeCount), 64'(strobesBefore));
    checkOutput("frame_err pulses", 64'(frameErrPulses), 64'd1);
    expQ.push_back({fb[8], fb[7], fb[6], fb[5], fb[4], fb[2], fb[1], fb[0]});
    expectedStrobes++;
    sendFrame(fb[8], 1'b1, 40);
    waitDrained("frame error drained");
`else
    fb = '{default: 8'h00};
    strobesBefore = strobeCount;
    checkOutput("strobes stable", 64'(strobeCount), 64'(strobesBefore + 0 * fb[0]));
`endif

    checkOutput("strobe count", 64'(strobeCount), 64'(expectedStrobes));
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
